// File: rtl/uart_tx_arbiter_if.sv
// Bundle for the two-requester UART packet arbiter: requester handshakes, UART byte port and status.
// The arbiter connects through the slave modport and its environment through the master modport.
interface uart_tx_arbiter_if #(
    parameter int unsigned PAYLOAD_BYTES = 8
) ();
    logic                       req0;
    logic [7:0]                 len0;
    logic [7:0]                 type0;
    logic [8*PAYLOAD_BYTES-1:0] data0;
    logic                       ack0;
    logic                       req1;
    logic [7:0]                 len1;
    logic [7:0]                 type1;
    logic [8*PAYLOAD_BYTES-1:0] data1;
    logic                       ack1;
    logic                       uart_transmit;
    logic [7:0]                 uart_tx_byte;
    logic                       uart_is_transmitting;
    logic                       busy;
    logic                       owner;

    modport master (
        output req0, len0, type0, data0, req1, len1, type1, data1, uart_is_transmitting,
        input  ack0, ack1, uart_transmit, uart_tx_byte, busy, owner
    );

    modport slave (
        input  req0, len0, type0, data0, req1, len1, type1, data1, uart_is_transmitting,
        output ack0, ack1, uart_transmit, uart_tx_byte, busy, owner
    );
endinterface

// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter that serialises one requester's packet (length, 0, 0, type, payload)
// onto a byte-wide UART transmitter, pacing strobes against the UART busy flag.
module uart_tx_arbiter #(
    parameter int unsigned PAYLOAD_BYTES = 8,
    parameter int unsigned MAX_LEN       = 4 + PAYLOAD_BYTES
) (
    input  logic              sys_clk,
    input  logic              reset_n,
    uart_tx_arbiter_if.slave  bus
);
    localparam int unsigned DW      = 8 * PAYLOAD_BYTES;
    localparam logic [7:0]  MaxLenB = 8'(MAX_LEN);

    typedef enum logic [1:0] {StIdle, StSend, StHold, StDone} state_e;

    state_e          state_q, state_d;
    logic [7:0]      idx_q, idx_d;
    logic [7:0]      len_q, len_d;
    logic [7:0]      type_q, type_d;
    logic [DW-1:0]   data_q, data_d;
    logic            owner_q, owner_d;
    logic            last_q, last_d;
    logic            tx_q, tx_d;
    logic [7:0]      byte_q, byte_d;
    logic            ack0_q, ack0_d;
    logic            ack1_q, ack1_d;
    logic            busy_q, busy_d;

    logic            grant;
    logic [7:0]      raw_len;
    logic [7:0]      cur_byte;

    always_comb begin
        cur_byte = 8'h00;
        if (idx_q == 8'd1) begin
            cur_byte = len_q;
        end else if (idx_q == 8'd4) begin
            cur_byte = type_q;
        end else begin
            for (int i = 0; i < int'(PAYLOAD_BYTES); i++) begin
                if (idx_q == 8'(i + 5)) cur_byte = data_q[8*i +: 8];
            end
        end
    end

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        len_d   = len_q;
        type_d  = type_q;
        data_d  = data_q;
        owner_d = owner_q;
        last_d  = last_q;
        tx_d    = 1'b0;
        byte_d  = byte_q;
        ack0_d  = 1'b0;
        ack1_d  = 1'b0;
        grant   = 1'b0;
        raw_len = 8'd0;
        unique case (state_q)
            StIdle: begin
                if (bus.req0 || bus.req1) begin
                    // Contention goes to whoever was not served last.
                    grant   = (bus.req0 && bus.req1) ? ~last_q : bus.req1;
                    owner_d = grant;
                    raw_len = grant ? bus.len1 : bus.len0;
                    if (raw_len < 8'd4)         len_d = 8'd4;
                    else if (raw_len > MaxLenB) len_d = MaxLenB;
                    else                        len_d = raw_len;
                    type_d  = grant ? bus.type1 : bus.type0;
                    data_d  = grant ? bus.data1 : bus.data0;
                    idx_d   = 8'd1;
                    state_d = StSend;
                end
            end
            StSend: begin
                if (!bus.uart_is_transmitting) begin
                    tx_d    = 1'b1;
                    byte_d  = cur_byte;
                    state_d = StHold;
                end
            end
            StHold: begin
                // One dead cycle lets the UART raise its busy flag before the next look.
                if (idx_q == len_q) begin
                    state_d = StDone;
                end else begin
                    idx_d   = idx_q + 8'd1;
                    state_d = StSend;
                end
            end
            StDone: begin
                if (!bus.uart_is_transmitting) begin
                    ack0_d  = ~owner_q;
                    ack1_d  = owner_q;
                    last_d  = owner_q;
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
        busy_d = (state_d != StIdle);
    end

    always_ff @(posedge sys_clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= StIdle;
            idx_q   <= 8'd0;
            len_q   <= 8'd0;
            type_q  <= 8'd0;
            data_q  <= '0;
            owner_q <= 1'b0;
            last_q  <= 1'b1;
            tx_q    <= 1'b0;
            byte_q  <= 8'h00;
            ack0_q  <= 1'b0;
            ack1_q  <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            len_q   <= len_d;
            type_q  <= type_d;
            data_q  <= data_d;
            owner_q <= owner_d;
            last_q  <= last_d;
            tx_q    <= tx_d;
            byte_q  <= byte_d;
            ack0_q  <= ack0_d;
            ack1_q  <= ack1_d;
            busy_q  <= busy_d;
        end
    end

    assign bus.uart_transmit = tx_q;
    assign bus.uart_tx_byte  = byte_q;
    assign bus.ack0          = ack0_q;
    assign bus.ack1          = ack1_q;
    assign bus.busy          = busy_q;
    assign bus.owner         = owner_q;
endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Scoreboard bench for uart_tx_arbiter: expected bytes and ack owners are queued when a packet
// is requested and consumed as the DUT strobes the UART and pulses ack.
module tb_uart_tx_arbiter;
    localparam int unsigned PB  = 8;
    localparam int unsigned MXL = 4 + PB;

    logic sys_clk;
    logic reset_n;
    logic model_en;
    logic model_busy;
    logic stall_busy;
    logic busy_at_edge;
    int   model_cnt;

    int n_checks;
    int n_fail;
    int tx_count;
    logic prev_tx;
    logic prev_ack;

    logic [7:0] exp_bytes[$];
    logic       exp_owner[$];

    uart_tx_arbiter_if #(.PAYLOAD_BYTES(PB)) bus ();

    uart_tx_arbiter #(
        .PAYLOAD_BYTES(PB),
        .MAX_LEN      (MXL)
    ) dut (
        .sys_clk(sys_clk),
        .reset_n(reset_n),
        .bus    (bus)
    );

    assign bus.uart_is_transmitting = model_busy | stall_busy;

    initial begin
        sys_clk = 1'b0;
        forever #5 sys_clk = ~sys_clk;
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // The value the DUT saw for the busy flag at the most recent rising edge.
    always @(posedge sys_clk) busy_at_edge <= bus.uart_is_transmitting;

    // Simple UART model: busy for three cycles after each strobe.
    initial begin
        model_cnt  = 0;
        model_busy = 1'b0;
        forever begin
            @(negedge sys_clk);
            if (model_en && bus.uart_transmit === 1'b1) model_cnt = 3;
            else if (model_cnt > 0) model_cnt--;
            model_busy = (model_cnt != 0);
        end
    end

    initial begin
        logic [7:0] eb;
        logic       eo;
        prev_tx  = 1'b0;
        prev_ack = 1'b0;
        forever begin
            @(negedge sys_clk);
            if (bus.uart_transmit === 1'b1) begin
                check_eq("tx_gap", 32'(prev_tx), 0);
                check_eq("tx_while_busy", 32'(busy_at_edge), 0);
                if (exp_bytes.size() == 0) begin
                    check_eq("tx_unexpected", exp_bytes.size(), 1);
                end else begin
                    eb = exp_bytes.pop_front();
                    check_eq("tx_byte", 32'(bus.uart_tx_byte), 32'(eb));
                end
                tx_count++;
            end
            if (bus.ack0 === 1'b1 || bus.ack1 === 1'b1) begin
                check_eq("ack_onehot", 32'(bus.ack0 & bus.ack1), 0);
                check_eq("ack_width", 32'(prev_ack), 0);
                check_eq("ack_while_busy", 32'(busy_at_edge), 0);
                if (exp_owner.size() == 0) begin
                    check_eq("ack_unexpected", exp_owner.size(), 1);
                end else begin
                    eo = exp_owner.pop_front();
                    check_eq("ack_owner", 32'(bus.ack1), 32'(eo));
                end
            end
            prev_tx  = bus.uart_transmit;
            prev_ack = bus.ack0 | bus.ack1;
        end
    end

    // Independent packet model: clamp the length, then length, 0, 0, type, payload bytes.
    task automatic push_pkt(input logic ch, input logic [7:0] len, input logic [7:0] typ,
                            input logic [8*PB-1:0] data);
        int l;
        l = (len < 4) ? 4 : ((len > MXL) ? MXL : int'(len));
        exp_bytes.push_back(8'(l));
        exp_bytes.push_back(8'h00);
        exp_bytes.push_back(8'h00);
        exp_bytes.push_back(typ);
        for (int k = 5; k <= l; k++) exp_bytes.push_back(data[8*(k-5) +: 8]);
        exp_owner.push_back(ch);
    endtask

    task automatic start_pkt(input logic ch, input logic [7:0] len, input logic [7:0] typ,
                             input logic [8*PB-1:0] data);
        push_pkt(ch, len, typ, data);
        if (ch) begin
            bus.len1 = len; bus.type1 = typ; bus.data1 = data; bus.req1 = 1'b1;
        end else begin
            bus.len0 = len; bus.type0 = typ; bus.data0 = data; bus.req0 = 1'b1;
        end
    endtask

    task automatic wait_ack(input logic ch);
        logic got;
        got = 1'b0;
        for (int i = 0; i < 3000; i++) begin
            @(negedge sys_clk);
            if ((ch ? bus.ack1 : bus.ack0) === 1'b1) begin
                got = 1'b1;
                break;
            end
        end
        if (ch) bus.req1 = 1'b0;
        else    bus.req0 = 1'b0;
        check_eq("ack_wait", 32'(got), 1);
        #1;
        check_eq("bytes_left", exp_bytes.size(), 0);
    endtask

    task automatic wait_tx(input int n);
        int target;
        target = tx_count + n;
        for (int i = 0; i < 2000 && tx_count < target; i++) begin
            @(negedge sys_clk);
            #1;
        end
        check_eq("tx_wait", 32'(tx_count >= target), 1);
    endtask

    task automatic pulse_reset();
        @(negedge sys_clk);
        reset_n = 1'b0;
        repeat (2) @(negedge sys_clk);
        reset_n = 1'b1;
        @(negedge sys_clk);
        #1;
    endtask

    initial begin
        int t0;
        int nack;
        n_checks = 0;
        n_fail   = 0;
        tx_count = 0;
        model_en = 1'b0;
        stall_busy = 1'b0;
        reset_n  = 1'b0;
        bus.req0 = 1'b0; bus.len0 = 8'd0; bus.type0 = 8'd0; bus.data0 = '0;
        bus.req1 = 1'b0; bus.len1 = 8'd0; bus.type1 = 8'd0; bus.data1 = '0;
        #1;
        check_eq("rst_transmit", 32'(bus.uart_transmit), 0);
        check_eq("rst_byte", 32'(bus.uart_tx_byte), 0);
        check_eq("rst_ack", 32'({bus.ack1, bus.ack0}), 0);
        check_eq("rst_busy", 32'(bus.busy), 0);
        check_eq("rst_owner", 32'(bus.owner), 0);
        repeat (2) @(negedge sys_clk);
        reset_n = 1'b1;
        @(negedge sys_clk);
        #1;

        // Reference packet with first-strobe latency.
        start_pkt(1'b0, 8'd12, 8'h00, 64'hDEADBEEF13370D13);
        @(negedge sys_clk);
        check_eq("grant_busy", 32'(bus.busy), 1);
        check_eq("grant_no_tx", 32'(bus.uart_transmit), 0);
        @(negedge sys_clk);
        check_eq("first_tx", 32'(bus.uart_transmit), 1);
        wait_ack(1'b0);
        @(negedge sys_clk);
        check_eq("idle_busy", 32'(bus.busy), 0);
        #1;

        // Contention from reset: 0 first, then strict alternation.
        pulse_reset();
        push_pkt(1'b0, 8'd5, 8'hA0, 64'h0000_0000_0000_0055);
        push_pkt(1'b1, 8'd6, 8'hB1, 64'h0000_0000_0000_7766);
        push_pkt(1'b0, 8'd5, 8'hA0, 64'h0000_0000_0000_0055);
        push_pkt(1'b1, 8'd6, 8'hB1, 64'h0000_0000_0000_7766);
        bus.len0 = 8'd5; bus.type0 = 8'hA0; bus.data0 = 64'h55;
        bus.len1 = 8'd6; bus.type1 = 8'hB1; bus.data1 = 64'h7766;
        bus.req0 = 1'b1; bus.req1 = 1'b1;
        nack = 0;
        for (int i = 0; i < 3000 && nack < 4; i++) begin
            @(negedge sys_clk);
            if (bus.ack0 === 1'b1 || bus.ack1 === 1'b1) nack++;
        end
        bus.req0 = 1'b0; bus.req1 = 1'b0;
        check_eq("alt_acks", nack, 4);
        #1;
        check_eq("alt_bytes_left", exp_bytes.size(), 0);

        // Length clamping on requester 1.
        start_pkt(1'b1, 8'd2, 8'h01, 64'h1122334455667788);
        @(negedge sys_clk);
        check_eq("owner1", 32'(bus.owner), 1);
        wait_ack(1'b1);
        start_pkt(1'b1, 8'h40, 8'h02, 64'h0807060504030201);
        wait_ack(1'b1);

        // UART stalled for 50 cycles mid-packet.
        start_pkt(1'b0, 8'd12, 8'h33, 64'hF0E1D2C3B4A59687);
        wait_tx(3);
        stall_busy = 1'b1;
        t0 = tx_count;
        repeat (50) @(negedge sys_clk);
        #1;
        check_eq("stall_no_tx", tx_count - t0, 0);
        stall_busy = 1'b0;
        wait_ack(1'b0);

        // Inputs changed and req dropped mid-packet.
        start_pkt(1'b0, 8'd11, 8'h44, 64'h0123456789ABCDEF);
        wait_tx(3);
        bus.data0 = 64'hFFFF_FFFF_FFFF_FFFF;
        bus.len0  = 8'd4;
        bus.type0 = 8'hEE;
        bus.req0  = 1'b0;
        wait_ack(1'b0);

        // Reset after the sixth byte abandons the packet.
        start_pkt(1'b1, 8'd12, 8'h66, 64'h1111_1111_1111_A5C3);
        wait_tx(6);
        reset_n = 1'b0;
        #1;
        check_eq("mid_rst_transmit", 32'(bus.uart_transmit), 0);
        check_eq("mid_rst_byte", 32'(bus.uart_tx_byte), 0);
        check_eq("mid_rst_busy", 32'(bus.busy), 0);
        check_eq("mid_rst_owner", 32'(bus.owner), 0);
        check_eq("mid_rst_ack", 32'({bus.ack1, bus.ack0}), 0);
        exp_bytes.delete();
        exp_owner.delete();
        bus.req1 = 1'b0;
        repeat (3) @(negedge sys_clk);
        reset_n = 1'b1;
        @(negedge sys_clk);
        #1;
        start_pkt(1'b1, 8'd9, 8'h77, 64'h0000_00AB_CDEF_0102);
        wait_ack(1'b1);

        // Realistic UART busy flag after every strobe.
        model_en = 1'b1;
        start_pkt(1'b1, 8'd7, 8'h5A, 64'h0000_0000_00C0_FFEE);
        wait_ack(1'b1);
        model_en = 1'b0;
        repeat (5) @(negedge sys_clk);
        #1;
        check_eq("end_owner_left", exp_owner.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
